// File: rtl/pipeline_sink_pkg.sv
// Shared widths for the pipeline tail; every block sizes address/id buses from here.
// Combinational helpers only, no state.
package pipeline_sink_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int ID_WIDTH      = 8;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_sink_fifo.sv
// sink_fifo: DEPTH-entry circular buffer holding address/id pairs from the last stage.
// Latency: head visible one cycle after push into empty (no bypass).
// Backpressure: caller must not push when full; pop only when rd_valid & rd_ready.
module sink_fifo
    import pipeline_sink_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [ID_WIDTH-1:0]      wr_id,
    input  logic                     rd_ready,
    output logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic [ID_WIDTH-1:0]      rd_id,
    output logic                     rd_valid,
    output logic [OCC_W-1:0]         occupancy
);

    logic [ADDRESS_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [ID_WIDTH-1:0]      id_mem_q   [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [OCC_W-1:0]         occ_q;
    logic [OCC_W-1:0]         occ_d;
    logic                     pop;

    assign rd_valid   = (occ_q != '0);
    assign pop        = rd_valid & rd_ready;
    assign rd_address = addr_mem_q[rd_ptr_q];
    assign rd_id      = id_mem_q[rd_ptr_q];
    assign occupancy  = occ_q;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                id_mem_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= wr_address;
                id_mem_q[wr_ptr_q]   <= wr_id;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/pipeline_sink.sv
// Pipeline tail: captures last-stage entries into sink_fifo, broadcasts global stall, counts accepts.
// Latency: one cycle from accept to rd_valid; SINK_ID_CHECK_EN adds a sticky id-sequence checker.
// Backpressure: stall = full | ext_hold from registered state only; pop is independent of stall.
module pipeline_sink
    import pipeline_sink_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter int  CNT_WIDTH = 16,
    localparam int OCC_W     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic                     in_valid,
    input  logic                     ext_hold,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic [ID_WIDTH-1:0]      rd_id,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [OCC_W-1:0]         occupancy,
    output logic [CNT_WIDTH-1:0]     accept_count
`ifdef SINK_ID_CHECK_EN
    ,
    output logic                     seq_err
`endif
);

    logic                 push;
    logic [CNT_WIDTH-1:0] accept_count_q;

    // A full FIFO refuses the push even if it pops this cycle; stall drops next cycle.
    assign stall        = (occupancy == OCC_W'(DEPTH)) | ext_hold;
    assign push         = in_valid & ~stall;
    assign accept_count = accept_count_q;

    sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wr_address (in_address),
        .wr_id      (in_id),
        .rd_ready   (rd_ready),
        .rd_address (rd_address),
        .rd_id      (rd_id),
        .rd_valid   (rd_valid),
        .occupancy  (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_count_q <= '0;
        end else if (push) begin
            accept_count_q <= accept_count_q + 1'b1;
        end
    end

`ifdef SINK_ID_CHECK_EN
    logic [ID_WIDTH-1:0] exp_id_q;
    logic                seq_err_q;

    assign seq_err = seq_err_q;

    // Expected id resyncs to the observed id after every push, so one gap flags once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_id_q  <= '0;
            seq_err_q <= 1'b0;
        end else if (push) begin
            exp_id_q <= next_id(in_id);
            if (in_id != exp_id_q) begin
                seq_err_q <= 1'b1;
            end
        end
    end
`endif

endmodule
